fec_descrambler: RTL and testbench

Receive-path stage directly downstream of FEC correction. It consumes corrected 65-bit transcoded blocks and restores the 2-bit 64b/66b sync header from the transcode bit. It descrambles the 64-bit payload with the self-synchronous x^58+x^39+1 polynomial and emits 66-bit blocks to the PCS decoder. It also maintains a block-type error counter for CSR.

---
 rtl/fec_pkg.sv | 35 +++
 rtl/fec_descr_core.sv | 26 ++
 rtl/fec_descrambler.sv | 126 ++++++++++++
 tb/tb_fec_descrambler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
// Shared types and constants for the FEC receive-path descrambler.
package fec_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StRun   = 2'd2
    } fec_state_e;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // x^58 + x^39 + 1
    localparam int unsigned DESCR_TAP_A = 58;
    localparam int unsigned DESCR_TAP_B = 39;
    localparam int unsigned HIST_W      = DESCR_TAP_A;

    localparam int unsigned NUM_BTYPES = 15;
    localparam logic [7:0] BTYPE_LIST [NUM_BTYPES] = '{
        8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
        8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF
    };

    function automatic logic btype_valid(input logic [7:0] btype);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_BTYPES); i++) begin
            if (btype == BTYPE_LIST[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/fec_descr_core.sv
// Combinational self-synchronous descrambler for one 64-bit block; also
// produces the history the next block needs.
module fec_descr_core
    import fec_pkg::*;
(
    input  logic [63:0]       c_blk_i,
    input  logic [HIST_W-1:0] hist_i,
    output logic [63:0]       payload_o,
    output logic [HIST_W-1:0] hist_o
);

    localparam int unsigned TapOff = DESCR_TAP_A - DESCR_TAP_B;
    localparam int unsigned XW     = 64 + TapOff;

    // Only the low XW bits of {block, history} are ever tapped.
    logic [XW-1:0] x;

    always_comb begin
        x = {c_blk_i[XW-HIST_W-1:0], hist_i};
        for (int i = 0; i < 64; i++) begin
            payload_o[i] = c_blk_i[i] ^ x[i + int'(TapOff)] ^ x[i];
        end
        hist_o = c_blk_i[63:64-HIST_W];
    end

endmodule

// File: rtl/fec_descrambler.sv
// Restores 64b/66b sync headers and descrambles corrected 65-bit blocks.
// Optional block-type checker and bad-block counter: FEC_DESCR_BTYPE_CHK_EN.
module fec_descrambler
    import fec_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             C_BLK_ENA,
    input  logic [64:0]      C_BLK,
    input  logic             CSR_STAT_FEC_LOCK,
    input  logic             CSR_CNT_CLR,
    output logic             D_BLK_ENA,
    output logic [65:0]      D_BLK,
    output logic [CNT_W-1:0] CSR_STAT_BAD_BLK,
    output logic             CSR_STAT_DESCR_RUN
);

    fec_state_e        state_q, state_d;
    logic [HIST_W-1:0] hist_q, hist_d, hist_next;
    logic [63:0]       payload;
    logic              d_ena_q, d_ena_d;
    logic [65:0]       d_blk_q, d_blk_d;
    logic              run_q, run_d;
    logic [1:0]        sync_hdr;

    fec_descr_core u_core (
        .c_blk_i   (C_BLK[63:0]),
        .hist_i    (hist_q),
        .payload_o (payload),
        .hist_o    (hist_next)
    );

    assign sync_hdr = C_BLK[64] ? SYNC_CTRL : SYNC_DATA;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        d_ena_d = 1'b0;
        d_blk_d = d_blk_q;
        run_d   = (state_q == StRun);
        if (!CSR_STAT_FEC_LOCK) begin
            state_d = StIdle;
            hist_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPrime;
                    hist_d  = '0;
                end
                StPrime: begin
                    // Seed block only loads history; nothing is emitted.
                    if (C_BLK_ENA) begin
                        state_d = StRun;
                        hist_d  = hist_next;
                    end
                end
                StRun: begin
                    if (C_BLK_ENA) begin
                        hist_d  = hist_next;
                        d_ena_d = 1'b1;
                        d_blk_d = {sync_hdr, payload};
                    end
                end
                default: begin
                    state_d = StIdle;
                    hist_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            hist_q  <= '0;
            d_ena_q <= 1'b0;
            d_blk_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            d_ena_q <= d_ena_d;
            d_blk_q <= d_blk_d;
            run_q   <= run_d;
        end
    end

    assign D_BLK_ENA          = d_ena_q;
    assign D_BLK              = d_blk_q;
    assign CSR_STAT_DESCR_RUN = run_q;

`ifdef FEC_DESCR_BTYPE_CHK_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bad_blk;

    assign bad_blk = CSR_STAT_FEC_LOCK && C_BLK_ENA && (state_q == StRun) && C_BLK[64]
                     && !btype_valid(payload[7:0]);

    always_comb begin
        cnt_d = cnt_q;
        if (CSR_CNT_CLR) begin
            cnt_d = '0;
        end else if (bad_blk && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CSR_STAT_BAD_BLK = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr   = CSR_CNT_CLR;
    assign CSR_STAT_BAD_BLK = '0;
`endif

endmodule

// File: tb/tb_fec_descrambler.sv
// Directed bench for fec_descrambler with a serial reference descrambler and
// an output scoreboard.
module tb_fec_descrambler;

    localparam int unsigned CNT_W = 16;
`ifdef FEC_DESCR_BTYPE_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             C_BLK_ENA;
    logic [64:0]      C_BLK;
    logic             CSR_STAT_FEC_LOCK;
    logic             CSR_CNT_CLR;
    logic             D_BLK_ENA;
    logic [65:0]      D_BLK;
    logic [CNT_W-1:0] CSR_STAT_BAD_BLK;
    logic             CSR_STAT_DESCR_RUN;

    fec_descrambler #(.CNT_W(CNT_W)) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .C_BLK_ENA          (C_BLK_ENA),
        .C_BLK              (C_BLK),
        .CSR_STAT_FEC_LOCK  (CSR_STAT_FEC_LOCK),
        .CSR_CNT_CLR        (CSR_CNT_CLR),
        .D_BLK_ENA          (D_BLK_ENA),
        .D_BLK              (D_BLK),
        .CSR_STAT_BAD_BLK   (CSR_STAT_BAD_BLK),
        .CSR_STAT_DESCR_RUN (CSR_STAT_DESCR_RUN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 idle, 1 prime, 2 run.
    int               m_state;
    logic [57:0]      m_sr;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ena;
    logic             m_run;
    logic [65:0]      m_blk;
    logic [65:0]      sb_q[$];

    // Bit-serial descrambler: sr[k] is the scrambled bit received k+1 bits ago.
    function automatic void ref_descr(input logic [63:0] c, input logic [57:0] sr_i,
                                      output logic [63:0] o, output logic [57:0] sr_o);
        logic [57:0] s;
        s = sr_i;
        for (int i = 0; i < 64; i++) begin
            o[i] = c[i] ^ s[38] ^ s[57];
            s    = {s[56:0], c[i]};
        end
        sr_o = s;
    endfunction

    function automatic logic type_ok(input logic [7:0] t);
        case (t)
            8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
            8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Block whose descrambled type byte (given current model history) is want.
    function automatic logic [64:0] mk_blk(input logic ctrl, input logic [7:0] want,
                                           input logic [55:0] hi);
        logic [63:0] o;
        logic [57:0] s;
        ref_descr({hi, 8'h00}, m_sr, o, s);
        return {ctrl, hi, o[7:0] ^ want};
    endfunction

    function automatic logic [64:0] rnd_blk();
        return {1'($urandom_range(0, 1)), $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_sr    = '0;
        m_cnt   = '0;
        m_ena   = 1'b0;
        m_run   = 1'b0;
        m_blk   = '0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic lock, input logic ena, input logic [64:0] blk,
                              input logic clr);
        logic [63:0] o;
        logic [57:0] s;
        logic        bad;
        int          nxt;
        bad   = 1'b0;
        nxt   = m_state;
        m_ena = 1'b0;
        m_run = (m_state == 2);
        if (!lock) begin
            nxt  = 0;
            m_sr = '0;
        end else if (m_state == 0) begin
            nxt  = 1;
            m_sr = '0;
        end else if (ena) begin
            ref_descr(blk[63:0], m_sr, o, s);
            m_sr = s;
            if (m_state == 1) begin
                nxt = 2;
            end else begin
                m_ena = 1'b1;
                m_blk = {(blk[64] ? 2'b10 : 2'b01), o};
                sb_q.push_back(m_blk);
                bad = blk[64] && !type_ok(o[7:0]);
            end
        end
        m_state = nxt;
        if (ChkEn) begin
            if (clr) m_cnt = '0;
            else if (bad && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [65:0] exp;
        check("d_blk_ena", 66'(D_BLK_ENA), 66'(m_ena));
        if (D_BLK_ENA) begin
            if (sb_q.size() == 0) begin
                check("d_blk_unexpected", 66'(D_BLK_ENA), 66'(0));
            end else begin
                exp = sb_q.pop_front();
                check("d_blk", D_BLK, exp);
            end
        end else begin
            check("d_blk_hold", D_BLK, m_blk);
        end
        check("descr_run", 66'(CSR_STAT_DESCR_RUN), 66'(m_run));
        check("bad_cnt", 66'(CSR_STAT_BAD_BLK), 66'(m_cnt));
    endtask

    task automatic step(input logic lock, input logic ena, input logic [64:0] blk,
                        input logic clr);
        CSR_STAT_FEC_LOCK = lock;
        C_BLK_ENA         = ena;
        C_BLK             = blk;
        CSR_CNT_CLR       = clr;
        model_step(lock, ena, blk, clr);
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ena"}, 66'(D_BLK_ENA), 66'(0));
        check({tag, "_blk"}, D_BLK, 66'(0));
        check({tag, "_cnt"}, 66'(CSR_STAT_BAD_BLK), 66'(0));
        check({tag, "_run"}, 66'(CSR_STAT_DESCR_RUN), 66'(0));
    endtask

    initial begin
        logic [64:0] b;
        int          low_cnt;
        logic [CNT_W-1:0] cnt_before;

        RST_N             = 1'b0;
        C_BLK_ENA         = 1'b0;
        C_BLK             = '0;
        CSR_STAT_FEC_LOCK = 1'b0;
        CSR_CNT_CLR       = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;

        // Seed with zeros, then a single set bit.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, '0, 1'b0);
        check("seed_no_out", 66'(D_BLK_ENA), 66'(0));
        step(1'b1, 1'b1, 65'h0_0000_0000_0000_0001, 1'b0);
        check("single_bit", D_BLK, 66'h1_0400_0080_0000_0001);

        // Parity gap inside a random stream.
        low_cnt = 0;
        for (int i = 0; i < 65; i++) begin
            if (i == 32) step(1'b1, 1'b0, rnd_blk(), 1'b0);
            else         step(1'b1, 1'b1, rnd_blk(), 1'b0);
            if (!D_BLK_ENA) low_cnt++;
        end
        check("gap_low_cycles", 66'(low_cnt), 66'(1));

        // Block-type checks.
        step(1'b1, 1'b0, '0, 1'b1);
        cnt_before = CSR_STAT_BAD_BLK;
        check("cnt_cleared", 66'(cnt_before), 66'(0));
        b = mk_blk(1'b1, 8'h00, {$urandom, 24'($urandom)});
        step(1'b1, 1'b1, b, 1'b0);
        check("bad_type_00", 66'(CSR_STAT_BAD_BLK), 66'(ChkEn ? 1 : 0));
        b = mk_blk(1'b1, 8'h1E, {$urandom, 24'($urandom)});
        step(1'b1, 1'b1, b, 1'b0);
        check("good_type_1e", 66'(CSR_STAT_BAD_BLK), 66'(ChkEn ? 1 : 0));
        b = mk_blk(1'b0, 8'h00, {$urandom, 24'($urandom)});
        step(1'b1, 1'b1, b, 1'b0);
        check("data_low_00", 66'(CSR_STAT_BAD_BLK), 66'(ChkEn ? 1 : 0));

        // Saturation, then clear coincident with an error.
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b1, mk_blk(1'b1, 8'h00, '0), 1'b0);
        end
        check("cnt_saturated", 66'(CSR_STAT_BAD_BLK), 66'(ChkEn ? 16'hFFFF : 16'h0));
        step(1'b1, 1'b1, mk_blk(1'b1, 8'h00, '0), 1'b1);
        check("clr_wins", 66'(CSR_STAT_BAD_BLK), 66'(0));

        // One-cycle lock drop with a valid block present.
        step(1'b1, 1'b1, rnd_blk(), 1'b0);
        step(1'b0, 1'b1, rnd_blk(), 1'b0);
        check("lockdrop_no_out", 66'(D_BLK_ENA), 66'(0));
        step(1'b1, 1'b0, rnd_blk(), 1'b0);
        check("lockdrop_run_low", 66'(CSR_STAT_DESCR_RUN), 66'(0));
        step(1'b1, 1'b1, rnd_blk(), 1'b0);
        check("relock_seed_no_out", 66'(D_BLK_ENA), 66'(0));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rnd_blk(), 1'b0);
        check("relock_run", 66'(CSR_STAT_DESCR_RUN), 66'(1));

        // Asynchronous reset mid-RUN.
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, rnd_blk(), 1'b0);
        check("post_rst_seed", 66'(D_BLK_ENA), 66'(0));
        step(1'b1, 1'b1, rnd_blk(), 1'b0);
        check("post_rst_out", 66'(D_BLK_ENA), 66'(1));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rnd_blk(), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);

        check("sb_drained", 66'(sb_q.size()), 66'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
